// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered read data, optional
// hard-wired zero entry and optional same-cycle write-to-read forwarding.
module reg_file_2r1w #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdataA_q, rdataA_d;
  logic [WIDTH-1:0] rdataB_q, rdataB_d;
  logic             rvalidA_q, rvalidB_q;
  logic             waddrInRange;
  logic             wAccept;

  // When DEPTH fills the whole address space every write address is legal.
  if (DEPTH == (1 << AW)) begin : gFullDecode
    assign waddrInRange = 1'b1;
  end else begin : gPartialDecode
    assign waddrInRange = (waddr < AW'(DEPTH));
  end

  assign wAccept = we && waddrInRange && !(ZERO_R0 && (waddr == '0));

  // AND-OR selection; an address past DEPTH matches no entry and yields zero.
  function automatic logic [WIDTH-1:0] readMux(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] sel;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel |= mem_q[i] & {WIDTH{addr == AW'(i)}};
    end
    if (ZERO_R0 && (addr == '0)) begin
      sel = '0;
    end
    if (BYPASS && wAccept && (addr == waddr)) begin
      sel = wdata;
    end
    return sel;
  endfunction

  always_comb begin
    rdataA_d = readMux(raddr_a);
    rdataB_d = readMux(raddr_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wAccept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  // Read data holds while its port is idle; valid marks a fresh result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdataA_q  <= '0;
      rdataB_q  <= '0;
      rvalidA_q <= 1'b0;
      rvalidB_q <= 1'b0;
    end else begin
      rvalidA_q <= re_a;
      rvalidB_q <= re_b;
      if (re_a) begin
        rdataA_q <= rdataA_d;
      end
      if (re_b) begin
        rdataB_q <= rdataB_d;
      end
    end
  end

  assign rdata_a  = rdataA_q;
  assign rdata_b  = rdataB_q;
  assign rvalid_a = rvalidA_q;
  assign rvalid_b = rvalidB_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: default build, a non-forwarding build
// sharing its inputs, and a narrow 12-entry build.
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst_n;

  logic        we, reA, reB;
  logic [4:0]  waddr, raddrA, raddrB;
  logic [31:0] wdata;
  logic [31:0] rdataA0, rdataB0, rdataA1, rdataB1;
  logic        rvalidA0, rvalidB0, rvalidA1, rvalidB1;

  logic        sWe, sReA, sReB;
  logic [3:0]  sWaddr, sRaddrA, sRaddrB;
  logic [7:0]  sWdata, sRdataA, sRdataB;
  logic        sRvalidA, sRvalidB;

  int assertions;
  int failures;

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(reA), .raddr_a(raddrA), .rdata_a(rdataA0), .rvalid_a(rvalidA0),
    .re_b(reB), .raddr_b(raddrB), .rdata_b(rdataB0), .rvalid_b(rvalidB0)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(reA), .raddr_a(raddrA), .rdata_a(rdataA1), .rvalid_a(rvalidA1),
    .re_b(reB), .raddr_b(raddrB), .rdata_b(rdataB1), .rvalid_b(rvalidB1)
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(12), .AW(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .we(sWe), .waddr(sWaddr), .wdata(sWdata),
    .re_a(sReA), .raddr_a(sRaddrA), .rdata_a(sRdataA), .rvalid_a(sRvalidA),
    .re_b(sReB), .raddr_b(sRaddrB), .rdata_b(sRdataB), .rvalid_b(sRvalidB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    we = 1'b0; reA = 1'b0; reB = 1'b0;
    waddr = '0; raddrA = '0; raddrB = '0; wdata = '0;
    sWe = 1'b0; sReA = 1'b0; sReB = 1'b0;
    sWaddr = '0; sRaddrA = '0; sRaddrB = '0; sWdata = '0;

    #12;
    checkOutput("reset_rdata_a", rdataA0, 32'h0);
    checkOutput("reset_rvalid_a", {31'b0, rvalidA0}, 32'h0);
    checkOutput("reset_rvalid_b", {31'b0, rvalidB0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Every entry reads zero after reset, valid one cycle after the enable.
    for (int i = 0; i < 32; i++) begin
      reA = 1'b1; reB = 1'b1;
      raddrA = 5'(i); raddrB = 5'(31 - i);
      tick();
      checkOutput($sformatf("sweep_rdata_a_%0d", i), rdataA0, 32'h0);
      checkOutput($sformatf("sweep_rdata_b_%0d", i), rdataB0, 32'h0);
      checkOutput($sformatf("sweep_rvalid_a_%0d", i), {31'b0, rvalidA0}, 32'h1);
      checkOutput($sformatf("sweep_rvalid_b_%0d", i), {31'b0, rvalidB0}, 32'h1);
    end
    reA = 1'b0; reB = 1'b0;
    tick();
    checkOutput("idle_rvalid_a", {31'b0, rvalidA0}, 32'h0);
    checkOutput("idle_rvalid_b", {31'b0, rvalidB0}, 32'h0);

    // Write then read.
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; reA = 1'b1; raddrA = 5'd7;
    tick();
    checkOutput("wr_rd_rdata_a", rdataA0, 32'hDEADBEEF);
    checkOutput("wr_rd_rvalid_a", {31'b0, rvalidA0}, 32'h1);
    reA = 1'b0;

    // Same-cycle bypass versus pre-write contents.
    we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
    tick();
    wdata = 32'h22222222; reB = 1'b1; raddrB = 5'd5;
    tick();
    checkOutput("bypass_on_rdata_b", rdataB0, 32'h22222222);
    checkOutput("bypass_off_rdata_b", rdataB1, 32'h11111111);
    we = 1'b0;
    tick();
    checkOutput("after_bypass_on", rdataB0, 32'h22222222);
    checkOutput("after_bypass_off", rdataB1, 32'h22222222);
    reB = 1'b0;

    // Writes to entry zero are dropped and never forwarded.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; reA = 1'b1; raddrA = 5'd0;
    tick();
    checkOutput("r0_same_cycle", rdataA0, 32'h0);
    tick();
    checkOutput("r0_next_cycle", rdataA0, 32'h0);
    we = 1'b0;
    tick();
    checkOutput("r0_after_writes", rdataA0, 32'h0);
    checkOutput("r0_after_writes_nobyp", rdataA1, 32'h0);
    reA = 1'b0;

    // Hold behaviour, dual-port agreement, then an asynchronous reset pulse.
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0; reA = 1'b1; raddrA = 5'd3; reB = 1'b1; raddrB = 5'd3;
    tick();
    checkOutput("hold_read_a", rdataA0, 32'hA5A5A5A5);
    checkOutput("dual_read_b", rdataB0, 32'hA5A5A5A5);
    reA = 1'b0; reB = 1'b0;
    tick();
    checkOutput("hold_rdata_a", rdataA0, 32'hA5A5A5A5);
    checkOutput("hold_rvalid_a", {31'b0, rvalidA0}, 32'h0);
    reA = 1'b1;
    tick();
    checkOutput("pre_reset_rvalid_a", {31'b0, rvalidA0}, 32'h1);
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset_rdata_a", rdataA0, 32'h0);
    checkOutput("async_reset_rvalid_a", {31'b0, rvalidA0}, 32'h0);
    rst_n = 1'b1;
    reA = 1'b0;
    tick();
    checkOutput("post_reset_rvalid_a", {31'b0, rvalidA0}, 32'h0);
    reA = 1'b1;
    tick();
    checkOutput("post_reset_read3", rdataA0, 32'h0);
    checkOutput("post_reset_read3_valid", {31'b0, rvalidA0}, 32'h1);
    checkOutput("post_reset_read7", 32'(u0.mem_q[7]) & 32'h0, 32'h0);
    reA = 1'b0;

    // Narrow build: in-range write, out-of-range write and read.
    sWe = 1'b1; sWaddr = 4'd11; sWdata = 8'h3C;
    tick();
    sWaddr = 4'd13; sWdata = 8'h77; sReA = 1'b1; sRaddrA = 4'd13;
    tick();
    checkOutput("narrow_oob_bypass", {24'b0, sRdataA}, 32'h0);
    checkOutput("narrow_oob_valid", {31'b0, sRvalidA}, 32'h1);
    sWe = 1'b0; sRaddrA = 4'd11; sReB = 1'b1; sRaddrB = 4'd13;
    tick();
    checkOutput("narrow_read11", {24'b0, sRdataA}, 32'h3C);
    checkOutput("narrow_read13", {24'b0, sRdataB}, 32'h0);
    checkOutput("narrow_read13_valid", {31'b0, sRvalidB}, 32'h1);
    sReA = 1'b0; sReB = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
